// File: rtl/slice_feeder.sv
// Lane-to-slice transposer: buffers 25 x 64-bit lanes, then streams 64 x 25-bit slices.
// SLICE_FEEDER_DOUBLE_BUF_EN selects ping-pong banks so loading overlaps emission.
module slice_feeder #(
   parameter int LANE_W = 64,
   parameter int LANE_N = 25
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [LANE_W-1:0] laneIn,
   input  logic              laneValid,
   output logic              laneReady,
   output logic [LANE_N-1:0] sliceOut,
   output logic              sliceValid,
   input  logic              sliceReady,
   output logic              sliceFirst,
   output logic              sliceLast,
   output logic              busy
);
   localparam int LC_W = $clog2(LANE_N);
   localparam int SC_W = $clog2(LANE_W);
   localparam logic [LC_W-1:0] LANE_LAST  = LC_W'(LANE_N - 1);
   localparam logic [SC_W-1:0] SLICE_LAST = SC_W'(LANE_W - 1);

   logic [LC_W-1:0] lane_cnt;
   logic [SC_W-1:0] slice_cnt;
   logic            lane_xfer;
   logic            slice_xfer;
   logic            lane_done;
   logic            slice_done;

   assign lane_xfer  = laneValid && laneReady;
   assign slice_xfer = sliceValid && sliceReady;
   assign lane_done  = lane_xfer && (lane_cnt == LANE_LAST);
   assign slice_done = slice_xfer && (slice_cnt == SLICE_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_cnt  <= '0;
         slice_cnt <= '0;
      end else begin
         if (lane_xfer)
            lane_cnt <= lane_done ? '0 : lane_cnt + 1'b1;
         if (slice_xfer)
            slice_cnt <= slice_done ? '0 : slice_cnt + 1'b1;
      end
   end

`ifdef SLICE_FEEDER_DOUBLE_BUF_EN
   logic [LANE_W-1:0] buf_q [2][LANE_N];
   logic [1:0]        full_q;
   logic              load_sel;
   logic              emit_sel;

   assign laneReady  = !full_q[load_sel];
   assign sliceValid = full_q[emit_sel];

   // lane_done and slice_done always target different banks, so both may fire on one edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_q   <= '0;
         load_sel <= 1'b0;
         emit_sel <= 1'b0;
      end else begin
         if (lane_done) begin
            full_q[load_sel] <= 1'b1;
            load_sel         <= !load_sel;
         end
         if (slice_done) begin
            full_q[emit_sel] <= 1'b0;
            emit_sel         <= !emit_sel;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (lane_xfer)
         buf_q[load_sel][lane_cnt] <= laneIn;
   end

   always_comb begin
      sliceOut = '0;
      if (sliceValid)
         for (int l = 0; l < LANE_N; l++)
            sliceOut[l] = buf_q[emit_sel][l][slice_cnt];
   end

   assign busy = (lane_cnt != '0) || (|full_q);
`else
   // state | meaning
   // LOAD  | accepting lanes into the buffer, no slice output
   // EMIT  | presenting slices, lane input stalled
   typedef enum logic {LOAD, EMIT} state_t;

   state_t            state_q;
   state_t            state_d;
   logic [LANE_W-1:0] buf_q [LANE_N];

   assign laneReady  = (state_q == LOAD);
   assign sliceValid = (state_q == EMIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= LOAD;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD: if (lane_done)  state_d = EMIT;
         EMIT: if (slice_done) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (lane_xfer)
         buf_q[lane_cnt] <= laneIn;
   end

   always_comb begin
      sliceOut = '0;
      if (sliceValid)
         for (int l = 0; l < LANE_N; l++)
            sliceOut[l] = buf_q[l][slice_cnt];
   end

   assign busy = (lane_cnt != '0) || sliceValid;
`endif

   assign sliceFirst = sliceValid && (slice_cnt == '0);
   assign sliceLast  = sliceValid && (slice_cnt == SLICE_LAST);

endmodule

// File: tb/tb_slice_feeder.sv
// Directed bench for slice_feeder: reset, transpose, handshake gaps, back-to-back and reset recovery.
// Honours SLICE_FEEDER_DOUBLE_BUF_EN for the back-to-back timing expectations.
module tb_slice_feeder;
   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] laneIn;
   logic        laneValid;
   logic        laneReady;
   logic [24:0] sliceOut;
   logic        sliceValid;
   logic        sliceReady;
   logic        sliceFirst;
   logic        sliceLast;
   logic        busy;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_lanes [25];

   slice_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .laneIn    (laneIn),
      .laneValid (laneValid),
      .laneReady (laneReady),
      .sliceOut  (sliceOut),
      .sliceValid(sliceValid),
      .sliceReady(sliceReady),
      .sliceFirst(sliceFirst),
      .sliceLast (sliceLast),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [24:0] exp_slice(input int z);
      logic [24:0] r;
      for (int l = 0; l < 25; l++)
         r[l] = exp_lanes[l][z];
      return r;
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_lane_ready"}, 64'(laneReady), 64'd1);
      chk({tag, "_slice_valid"}, 64'(sliceValid), 64'd0);
      chk({tag, "_slice_out"}, 64'(sliceOut), 64'd0);
      chk({tag, "_first"}, 64'(sliceFirst), 64'd0);
      chk({tag, "_last"}, 64'(sliceLast), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic load_lanes(input int n_want, input bit gaps, input string tag);
      int n   = 0;
      int cyc = 0;
      bit xfer;
      while (n < n_want && cyc < 400) begin
         laneValid = !gaps || (cyc % 2 == 1);
         laneIn    = laneValid ? exp_lanes[n] : {$urandom, $urandom};
         xfer      = laneValid && laneReady;
         tick();
         if (xfer) n++;
         cyc++;
      end
      laneValid = 1'b0;
      chk({tag, "_lanes_loaded"}, 64'(n), 64'(n_want));
   endtask

   task automatic emit_check(input bit gaps, input string tag);
      int z   = 0;
      int cyc = 0;
      bit xfer;
      chk({tag, "_latency"}, 64'(sliceValid), 64'd1);
      while (z < 64 && cyc < 400) begin
         sliceReady = !gaps || (cyc % 2 == 0);
         chk($sformatf("%s_valid_%0d", tag, z), 64'(sliceValid), 64'd1);
         if (!sliceValid) break;
         chk($sformatf("%s_slice_%0d", tag, z), 64'(sliceOut), 64'(exp_slice(z)));
         chk($sformatf("%s_first_%0d", tag, z), 64'(sliceFirst), 64'(z == 0));
         chk($sformatf("%s_last_%0d", tag, z), 64'(sliceLast), 64'(z == 63));
         xfer = sliceValid && sliceReady;
         tick();
         if (xfer) z++;
         cyc++;
      end
      sliceReady = 1'b0;
      chk({tag, "_slices_sent"}, 64'(z), 64'd64);
      chk_idle({tag, "_after"});
   endtask

   initial begin
      int sent, low, sv, nfirst, first_sv, first2, n_cyc;
      bit lx;

      rst        = 1'b0;
      laneValid  = 1'b0;
      sliceReady = 1'b0;
      laneIn     = '0;
      for (int i = 0; i < 5; i++) begin
         laneValid  = 1'($urandom);
         sliceReady = 1'($urandom);
         laneIn     = {$urandom, $urandom};
         tick();
         chk_idle($sformatf("reset_%0d", i));
      end
      laneValid  = 1'b0;
      sliceReady = 1'b0;
      rst        = 1'b1;
      tick();
      chk_idle("post_reset");

      // Diagonal pattern: slice z is a one-hot at bit z for z < 25.
      for (int l = 0; l < 25; l++) exp_lanes[l] = 64'h1 << l;
      load_lanes(25, 1'b0, "diag");
      for (int z = 0; z < 64; z++)
         if (z == 0 || z == 24 || z == 25 || z == 63)
            chk($sformatf("diag_hand_%0d", z), 64'(exp_slice(z)),
                (z < 25) ? (64'h1 << z) : 64'h0);
      chk("diag_busy_emit", 64'(busy), 64'd1);
      emit_check(1'b0, "diag");

      for (int l = 0; l < 25; l++) exp_lanes[l] = (l == 0) ? '1 : '0;
      load_lanes(25, 1'b0, "lane0");
      chk("lane0_slice0_hand", 64'(sliceOut), 64'h1);
      emit_check(1'b0, "lane0");

      for (int l = 0; l < 25; l++) exp_lanes[l] = {$urandom, $urandom};
      load_lanes(25, 1'b1, "gaps");
      emit_check(1'b1, "gaps");

      // Back-to-back states, lane source limited to two states.
      for (int l = 0; l < 25; l++) exp_lanes[l] = {$urandom, $urandom};
`ifdef SLICE_FEEDER_DOUBLE_BUF_EN
      n_cyc = 153;
`else
      n_cyc = 178;
`endif
      sent = 0; low = 0; sv = 0; nfirst = 0; first_sv = -1; first2 = -1;
      sliceReady = 1'b1;
      for (int c = 0; c < n_cyc; c++) begin
         laneValid = (sent < 50);
         laneIn    = exp_lanes[sent % 25];
         if (!laneReady) low++;
         if (sliceValid) begin
            sv++;
            if (first_sv < 0) first_sv = c;
         end
         if (sliceFirst) begin
            nfirst++;
            if (nfirst == 2) first2 = c;
         end
         lx = laneValid && laneReady;
         tick();
         if (lx) sent++;
      end
      laneValid  = 1'b0;
      sliceReady = 1'b0;
      chk("b2b_lanes", 64'(sent), 64'd50);
      chk("b2b_slice_valid_cycles", 64'(sv), 64'd128);
      chk("b2b_first_valid", 64'(first_sv), 64'd25);
`ifdef SLICE_FEEDER_DOUBLE_BUF_EN
      chk("b2b_second_first", 64'(first2), 64'd89);
      chk("b2b_ready_low", 64'(low), 64'd39);
`else
      chk("b2b_second_first", 64'(first2), 64'd114);
      chk("b2b_ready_low", 64'(low), 64'd128);
`endif
      chk_idle("b2b_after");

      // Reset while slice 30 is presented.
      for (int l = 0; l < 25; l++) exp_lanes[l] = {$urandom, $urandom};
      load_lanes(25, 1'b0, "mid");
      sliceReady = 1'b1;
      for (int i = 0; i < 30; i++) tick();
      sliceReady = 1'b0;
      chk("mid_slice30", 64'(sliceOut), 64'(exp_slice(30)));
      #1 rst = 1'b0;
      #1 chk_idle("mid_async");
      tick();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("mid_no_valid_%0d", i), 64'(sliceValid), 64'd0);
      end
      for (int l = 0; l < 25; l++) exp_lanes[l] = ~(64'h1 << (2 * l));
      load_lanes(25, 1'b0, "mid_reload");
      emit_check(1'b0, "mid_reload");

      // Partial load discarded by reset.
      for (int l = 0; l < 25; l++) exp_lanes[l] = '1;
      load_lanes(10, 1'b0, "part");
      chk("part_busy", 64'(busy), 64'd1);
      #1 rst = 1'b0;
      #1 chk_idle("part_async");
      tick();
      rst = 1'b1;
      tick();
      for (int l = 0; l < 25; l++) exp_lanes[l] = {$urandom, $urandom};
      load_lanes(25, 1'b0, "part_reload");
      emit_check(1'b0, "part_reload");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
